cache_line_mem_master: RTL and testbench

Initiator for the cache controller's word-wide main memory port. It accepts one line-level command (refill or writeback) from the cache controller FSM and breaks it into WORDS_PER_LINE sequential word transactions on the memory interface. Each transaction is held until the memory returns `mem_ack`. The block sits between the cache controller and `main_memory`, drives the request side of that port, and consumes its response.

---
 rtl/cache_mem_pkg.sv | 26 ++
 rtl/cache_line_mem_master.sv | 146 ++++++++++++++
 tb/tb_cache_line_mem_master.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_pkg
// Description : Shared types and helpers for the cache main-memory master.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_mem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } mem_master_state_t;

    localparam int WORD_BYTES = 4;

    // Number of byte-offset bits covered by one cache line.
    function automatic int line_offset_bits(input int words);
        return $clog2(words * WORD_BYTES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_mem_master
// Description : Splits a line refill/writeback into sequential word
//               transactions on the main-memory port, with per-word timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_mem_master
    import cache_mem_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [31:0]                   cmd_line_addr,
    input  logic [32*WORDS_PER_LINE-1:0]  wb_data,
    output logic [32*WORDS_PER_LINE-1:0]  fill_data,
    output logic                          done,
    output logic                          error,
    output logic [31:0]                   mem_address,
    output logic                          mem_write_enable,
    output logic [31:0]                   mem_write_data,
    input  logic [31:0]                   mem_read_data,
    input  logic                          mem_ack
);

    localparam int                 c_idx_w        = $clog2(WORDS_PER_LINE);
    localparam int                 c_cnt_w        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0]        c_line_mask    = ~((32'd1 << line_offset_bits(WORDS_PER_LINE)) - 32'd1);
    localparam logic [c_idx_w-1:0] c_last_idx     = c_idx_w'(WORDS_PER_LINE - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    mem_master_state_t            r_state;
    mem_master_state_t            w_next_state;
    logic [31:0]                  r_base;
    logic                         r_write;
    logic [32*WORDS_PER_LINE-1:0] r_wb_data;
    logic [32*WORDS_PER_LINE-1:0] r_fill_data;
    logic [c_idx_w-1:0]           r_idx;
    logic [c_cnt_w-1:0]           r_wait_cnt;

    logic                         w_accept;
    logic                         w_last_word;
    logic                         w_timeout;
    logic [31:0]                  w_masked_addr;

    assign w_masked_addr = cmd_line_addr & c_line_mask;
    assign w_accept      = cmd_valid && (r_state == IDLE);
    assign w_last_word   = (r_idx == c_last_idx);
    // Last permitted ack-less WAIT cycle: the counter would reach TIMEOUT_CYCLES.
    assign w_timeout     = (r_wait_cnt == c_timeout_last);
    assign fill_data     = r_fill_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs depend only on state and registered command context.
    always_comb begin
        w_next_state     = r_state;
        cmd_ready        = 1'b0;
        done             = 1'b0;
        error            = 1'b0;
        mem_address      = 32'd0;
        mem_write_enable = 1'b0;
        mem_write_data   = 32'd0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (w_accept) begin
                    w_next_state = (w_masked_addr == 32'd0) ? ERR : ISSUE;
                end
            end
            ISSUE: begin
                mem_address      = r_base + (32'(r_idx) << 2);
                mem_write_enable = r_write;
                mem_write_data   = r_write ? r_wb_data[32*r_idx +: 32] : 32'd0;
                w_next_state     = WAIT;
            end
            WAIT: begin
                mem_address    = r_base + (32'(r_idx) << 2);
                mem_write_data = r_write ? r_wb_data[32*r_idx +: 32] : 32'd0;
                if (mem_ack) begin
                    w_next_state = w_last_word ? DONE : GAP;
                end else if (w_timeout) begin
                    w_next_state = ERR;
                end
            end
            GAP: begin
                w_next_state = ISSUE;
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            ERR: begin
                error        = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base      <= 32'd0;
            r_write     <= 1'b0;
            r_wb_data   <= '0;
            r_fill_data <= '0;
            r_idx       <= '0;
            r_wait_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_base    <= w_masked_addr;
                r_write   <= cmd_write;
                r_wb_data <= wb_data;
                r_idx     <= '0;
            end
            if (r_state == ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT && !mem_ack) begin
                r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
            end
            if (r_state == WAIT && mem_ack) begin
                if (!r_write) begin
                    r_fill_data[32*r_idx +: 32] <= mem_read_data;
                end
                if (!w_last_word) begin
                    r_idx <= r_idx + c_idx_w'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_line_mem_master
// Description : Directed self-checking bench with a latency-configurable
//               memory model for cache_line_mem_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_line_mem_master;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_write = 1'b0;
    logic [31:0]  cmd_line_addr = 32'd0;
    logic [127:0] wb_data = '0;
    logic [127:0] fill_data;
    logic         done;
    logic         error;
    logic [31:0]  mem_address;
    logic         mem_write_enable;
    logic [31:0]  mem_write_data;
    logic [31:0]  mem_read_data = 32'd0;
    logic         mem_ack = 1'b0;

    int checks   = 0;
    int failures = 0;

    cache_line_mem_master #(
        .WORDS_PER_LINE(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_line_addr    (cmd_line_addr),
        .wb_data          (wb_data),
        .fill_data        (fill_data),
        .done             (done),
        .error            (error),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .mem_ack          (mem_ack)
    );

    always #5 clk = ~clk;

    // Memory model: acks in the lat-th WAIT cycle, read data = address.
    int           lat        = 3;
    logic [31:0]  block_addr = 32'd0;
    logic         inject_ack = 1'b0;
    int           n_req = 0;
    int           we_cycles = 0;
    int           active_cycles = 0;
    int           stab_err = 0;
    logic [31:0]  hold_addr = 32'd0;
    logic [31:0]  hold_data = 32'd0;
    logic         hold_we = 1'b0;
    logic [31:0]  issue_log [$];
    logic [31:0]  mem_model [0:255];

    always @(negedge clk) begin
        if (mem_address != 32'd0) begin
            n_req = n_req + 1;
            active_cycles = active_cycles + 1;
            if (mem_write_enable) we_cycles = we_cycles + 1;
            if (n_req == 1) begin
                hold_addr = mem_address;
                hold_data = mem_write_data;
                hold_we   = mem_write_enable;
                issue_log.push_back(mem_address);
            end else if (mem_address !== hold_addr || mem_write_data !== hold_data
                         || mem_write_enable !== 1'b0) begin
                stab_err = stab_err + 1;
            end
            if (n_req == lat + 1 && mem_address != block_addr) begin
                mem_ack       = 1'b1;
                mem_read_data = mem_address;
                if (hold_we) mem_model[mem_address[9:2]] = mem_write_data;
            end else begin
                mem_ack       = inject_ack;
                mem_read_data = inject_ack ? 32'hDEAD_BEEF : 32'd0;
            end
        end else begin
            n_req         = 0;
            mem_ack       = inject_ack;
            mem_read_data = inject_ack ? 32'hDEAD_BEEF : 32'd0;
        end
    end

    // Issues one command and observes cycles 1..max_cyc after the accept edge.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [127:0] wdata,
                           input int max_cyc, output int done_cyc, output int err_cyc,
                           output int ready_cyc, output int n_done, output int n_err);
        done_cyc = -1; err_cyc = -1; ready_cyc = -1; n_done = 0; n_err = 0;
        @(negedge clk);
        cmd_write = wr; cmd_line_addr = addr; wb_data = wdata; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (c > 1) @(negedge clk);
            if (done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
            if (error) begin n_err++; if (err_cyc < 0) err_cyc = c; end
            if (cmd_ready && (done_cyc >= 0 || err_cyc >= 0)) begin
                ready_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
        checks++; if (fill_data !== 128'd0) begin failures++; $display("FAIL reset_fill got=%h want=0", fill_data); end
        checks++; if ({done, error, mem_write_enable} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b want=000", {done, error, mem_write_enable}); end
        checks++; if ({mem_address, mem_write_data} !== 64'd0) begin failures++; $display("FAIL reset_mem got=%h want=0", {mem_address, mem_write_data}); end
        rst = 1'b0;
    endtask

    task automatic test_refill();
        int dc, ec, rc, nd, ne, log0, we0, st0;
        lat = 3; log0 = issue_log.size(); we0 = we_cycles; st0 = stab_err;
        run_cmd(1'b0, 32'h100, '0, 60, dc, ec, rc, nd, ne);
        checks++; if (dc !== 20 || nd !== 1 || ne !== 0) begin failures++; $display("FAIL refill_done cyc=%0d n=%0d err=%0d want 20/1/0", dc, nd, ne); end
        checks++; if (rc !== 21) begin failures++; $display("FAIL refill_ready cyc=%0d want=21", rc); end
        checks++; if (fill_data !== 128'h0000010C_00000108_00000104_00000100) begin failures++; $display("FAIL refill_data got=%h", fill_data); end
        checks++; if (issue_log.size() - log0 !== 4) begin failures++; $display("FAIL refill_count got=%0d want=4", issue_log.size() - log0); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (issue_log[log0 + i] !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL refill_addr%0d got=%h want=%h", i, issue_log[log0 + i], 32'h100 + 32'(4 * i)); end
        end
        checks++; if (we_cycles - we0 !== 0 || stab_err - st0 !== 0) begin failures++; $display("FAIL refill_strobe we=%0d stab=%0d want 0/0", we_cycles - we0, stab_err - st0); end
    endtask

    task automatic test_writeback();
        int dc, ec, rc, nd, ne, we0, st0;
        lat = 4; we0 = we_cycles; st0 = stab_err;
        run_cmd(1'b1, 32'h240, 128'h000000A3_000000A2_000000A1_000000A0, 60, dc, ec, rc, nd, ne);
        checks++; if (dc !== 24 || nd !== 1 || ne !== 0) begin failures++; $display("FAIL wb_done cyc=%0d n=%0d err=%0d want 24/1/0", dc, nd, ne); end
        checks++; if (we_cycles - we0 !== 4) begin failures++; $display("FAIL wb_strobe got=%0d want=4", we_cycles - we0); end
        checks++; if (stab_err - st0 !== 0) begin failures++; $display("FAIL wb_stable got=%0d want=0", stab_err - st0); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_model[8'h90 + i] !== 32'hA0 + 32'(i)) begin failures++; $display("FAIL wb_mem%0d got=%h want=%h", i, mem_model[8'h90 + i], 32'hA0 + 32'(i)); end
        end
        checks++; if (fill_data !== 128'h0000010C_00000108_00000104_00000100) begin failures++; $display("FAIL wb_fill_kept got=%h", fill_data); end
    endtask

    task automatic test_unaligned();
        int dc, ec, rc, nd, ne, log0;
        lat = 1; log0 = issue_log.size();
        run_cmd(1'b0, 32'h10C, '0, 60, dc, ec, rc, nd, ne);
        checks++; if (dc !== 12 || nd !== 1) begin failures++; $display("FAIL unal_done cyc=%0d n=%0d want 12/1", dc, nd); end
        checks++; if (issue_log.size() - log0 !== 4) begin failures++; $display("FAIL unal_count got=%0d want=4", issue_log.size() - log0); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (issue_log[log0 + i] !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL unal_addr%0d got=%h want=%h", i, issue_log[log0 + i], 32'h100 + 32'(4 * i)); end
        end
    endtask

    task automatic test_line_zero();
        int dc, ec, rc, nd, ne, act0;
        act0 = active_cycles;
        run_cmd(1'b0, 32'h0000000C, '0, 20, dc, ec, rc, nd, ne);
        checks++; if (ec !== 1 || ne !== 1 || nd !== 0) begin failures++; $display("FAIL zero_err cyc=%0d n=%0d done=%0d want 1/1/0", ec, ne, nd); end
        checks++; if (rc !== 2) begin failures++; $display("FAIL zero_ready cyc=%0d want=2", rc); end
        checks++; if (active_cycles - act0 !== 0) begin failures++; $display("FAIL zero_activity got=%0d want=0", active_cycles - act0); end
    endtask

    task automatic test_timeout();
        int dc, ec, rc, nd, ne, late_pulses;
        lat = 2; block_addr = 32'h308;
        run_cmd(1'b0, 32'h300, '0, 60, dc, ec, rc, nd, ne);
        block_addr = 32'd0;
        checks++; if (ec !== 26 || ne !== 1 || nd !== 0) begin failures++; $display("FAIL tmo_err cyc=%0d n=%0d done=%0d want 26/1/0", ec, ne, nd); end
        checks++; if (fill_data !== 128'h0000010C_00000108_00000304_00000300) begin failures++; $display("FAIL tmo_fill got=%h", fill_data); end
        late_pulses = 0;
        @(negedge clk); inject_ack = 1'b1;
        @(negedge clk); inject_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || error || !cmd_ready) late_pulses++;
        end
        checks++; if (late_pulses !== 0) begin failures++; $display("FAIL late_ack_state got=%0d want=0", late_pulses); end
        checks++; if (fill_data !== 128'h0000010C_00000108_00000304_00000300) begin failures++; $display("FAIL late_ack_fill got=%h", fill_data); end
    endtask

    task automatic test_reset_mid_wait();
        int dc, ec, rc, nd, ne, seen;
        lat = 20; seen = 0;
        @(negedge clk);
        cmd_write = 1'b0; cmd_line_addr = 32'h400; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mem_address !== 32'h400) begin failures++; $display("FAIL mid_wait_addr got=%h want=00000400", mem_address); end
        #2 rst = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1 || {done, error, mem_write_enable} !== 3'b000) begin failures++; $display("FAIL mid_rst_ctrl ready=%b pulses=%b want 1/000", cmd_ready, {done, error, mem_write_enable}); end
        checks++; if ({mem_address, mem_write_data} !== 64'd0 || fill_data !== 128'd0) begin failures++; $display("FAIL mid_rst_mem addr=%h wdata=%h fill=%h want 0", mem_address, mem_write_data, fill_data); end
        @(negedge clk);
        if (done || error) seen++;
        rst = 1'b0;
        @(negedge clk);
        if (done || error) seen++;
        checks++; if (seen !== 0) begin failures++; $display("FAIL mid_rst_pulse got=%0d want=0", seen); end
        lat = 2;
        run_cmd(1'b0, 32'h180, '0, 60, dc, ec, rc, nd, ne);
        checks++; if (dc !== 16 || nd !== 1 || ne !== 0) begin failures++; $display("FAIL post_rst_done cyc=%0d n=%0d err=%0d want 16/1/0", dc, nd, ne); end
        checks++; if (fill_data !== 128'h0000018C_00000188_00000184_00000180) begin failures++; $display("FAIL post_rst_fill got=%h", fill_data); end
    endtask

    initial begin
        test_reset();
        test_refill();
        test_writeback();
        test_unaligned();
        test_line_zero();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
